// File: rtl/i2s_multi_msb_receiver.sv
// Multi-line I2S receiver: keeps the top SAMPLE_BITS of each slot and
// bursts them into a circular frame buffer, publishing only clean frames.
module i2s_multi_msb_receiver #(
   parameter int LINES         = 4,
   parameter int SAMPLE_BITS   = 24,
   parameter int SLOT_BITS     = 32,
   parameter int CIRC_BUF_BITS = 3
) (
   input  logic                   clk_x4_i,
   input  logic                   reset_n_i,
   input  logic                   i2s_running_i,
   input  logic                   i2s_bclk_i,
   input  logic                   i2s_lrclk_i,
   input  logic [LINES-1:0]       i2s_data_i,
   output logic [CIRC_BUF_BITS+$clog2(2*LINES)-1:0] ram_write_addr_o,
   output logic [SAMPLE_BITS-1:0] ram_write_data_o,
   output logic                   ram_write_en_o,
   output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
   output logic                   frame_error_o
);

   localparam int CHW = $clog2(2*LINES);
   localparam int CW  = $clog2(SLOT_BITS+1);
   localparam int BCW = $clog2(LINES)+1;

   localparam logic [CW-1:0] SLOT_MAX  = CW'(SLOT_BITS);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_BITS-1);
   localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_BITS);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SYNC,
      LEFT,
      RIGHT
   } state_t;

   state_t state_q, state_d;

   logic                     bclk_prev_q;
   logic                     lrclk_prev_q;
   logic [CW-1:0]            cnt_q, cnt_next;
   logic                     left_bad_q;
   logic [CIRC_BUF_BITS-1:0] frame_idx_q;
   logic [SAMPLE_BITS-2:0]   shift_q [LINES];
   logic [SAMPLE_BITS-1:0]   shift_d [LINES];
   logic [SAMPLE_BITS-1:0]   snap_q  [LINES];
   logic [SAMPLE_BITS-1:0]   burst_data;
   logic [BCW-1:0]           burst_cnt_q;
   logic                     burst_on_q;
   logic                     burst_right_q;

   logic bclk_edge, lr_change, lr_rise, lr_fall;
   logic in_slot, shift_en, capture, slot_ok;
   logic frame_end, frame_good;

   function automatic logic [CHW-1:0] chan_of(input int line,
                                              input logic right);
      return CHW'(2*line + int'(right));
   endfunction

   assign bclk_edge = i2s_bclk_i & ~bclk_prev_q;
   assign lr_change = bclk_edge & (i2s_lrclk_i ^ lrclk_prev_q);
   assign lr_rise   = lr_change & i2s_lrclk_i;
   assign lr_fall   = lr_change & ~i2s_lrclk_i;
   assign in_slot   = (state_q == LEFT) || (state_q == RIGHT);
   assign slot_ok   = (cnt_q == SLOT_LAST);

   always_comb begin
      if (lr_change)
         cnt_next = '0;
      else if (cnt_q == SLOT_MAX)
         cnt_next = cnt_q;
      else
         cnt_next = cnt_q + 1'b1;
   end

   // Count 0 is the lrclk change edge; the MSB arrives one edge later.
   assign shift_en = bclk_edge && in_slot && (cnt_next != '0)
                     && (cnt_next <= SAMP_LAST);
   assign capture  = shift_en && (cnt_next == SAMP_LAST) && i2s_running_i;

   assign frame_end  = (state_q == RIGHT) && lr_fall && i2s_running_i;
   assign frame_good = frame_end && !left_bad_q && slot_ok;

   always_comb begin
      for (int l = 0; l < LINES; l++)
         shift_d[l] = {shift_q[l], i2s_data_i[l]};
   end

   always_comb begin
      burst_data = '0;
      for (int l = 0; l < LINES; l++)
         if (burst_cnt_q == BCW'(l))
            burst_data = snap_q[l];
   end

   always_ff @(posedge clk_x4_i) begin
      if (!reset_n_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (i2s_running_i) state_d = WAIT_SYNC;
         WAIT_SYNC: if (lr_fall) state_d = LEFT;
         LEFT:      if (lr_rise) state_d = RIGHT;
         RIGHT:     if (lr_fall) state_d = LEFT;
         default:   state_d = IDLE;
      endcase
      if (!i2s_running_i)
         state_d = IDLE;
   end

   always_ff @(posedge clk_x4_i) begin
      if (!reset_n_i) begin
         bclk_prev_q           <= 1'b0;
         lrclk_prev_q          <= 1'b0;
         cnt_q                 <= '0;
         left_bad_q            <= 1'b0;
         frame_idx_q           <= '0;
         burst_cnt_q           <= '0;
         burst_on_q            <= 1'b0;
         burst_right_q         <= 1'b0;
         ram_write_addr_o      <= '0;
         ram_write_data_o      <= '0;
         ram_write_en_o        <= 1'b0;
         last_good_frame_idx_o <= '0;
         frame_error_o         <= 1'b0;
         for (int l = 0; l < LINES; l++) begin
            shift_q[l] <= '0;
            snap_q[l]  <= '0;
         end
      end else begin
         bclk_prev_q    <= i2s_bclk_i;
         frame_error_o  <= 1'b0;
         ram_write_en_o <= 1'b0;

         if (bclk_edge) begin
            lrclk_prev_q <= i2s_lrclk_i;
            cnt_q        <= cnt_next;
         end

         if (shift_en)
            for (int l = 0; l < LINES; l++)
               shift_q[l] <= shift_d[l][SAMPLE_BITS-2:0];

         if ((state_q == LEFT) && lr_rise)
            left_bad_q <= !slot_ok;

         // A bad frame keeps its index so the next frame overwrites it.
         if (frame_end) begin
            if (frame_good) begin
               last_good_frame_idx_o <= frame_idx_q;
               frame_idx_q           <= frame_idx_q + 1'b1;
            end else begin
               frame_error_o <= 1'b1;
            end
         end

         if (!i2s_running_i) begin
            burst_on_q <= 1'b0;
         end else if (capture) begin
            for (int l = 0; l < LINES; l++)
               snap_q[l] <= shift_d[l];
            ram_write_en_o   <= 1'b1;
            ram_write_addr_o <= {frame_idx_q,
                                 chan_of(0, state_q == RIGHT)};
            ram_write_data_o <= shift_d[0];
            burst_cnt_q      <= BCW'(1);
            burst_on_q       <= (LINES > 1);
            burst_right_q    <= (state_q == RIGHT);
         end else if (burst_on_q) begin
            ram_write_en_o   <= 1'b1;
            ram_write_addr_o <= {frame_idx_q,
                                 chan_of(int'(burst_cnt_q),
                                         burst_right_q)};
            ram_write_data_o <= burst_data;
            burst_cnt_q      <= burst_cnt_q + 1'b1;
            burst_on_q       <= (burst_cnt_q != BCW'(LINES-1));
         end
      end
   end

endmodule

// File: tb/tb_i2s_multi_msb_receiver.sv
// Directed bench for i2s_multi_msb_receiver: a 4-line default instance
// and a 1-line 16/17-bit instance driven from one linear sequence.
module tb_i2s_multi_msb_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, run, bclk, lrclk;
   logic [3:0]  din;
   logic [5:0]  addr;
   logic [23:0] wdata;
   logic        wen;
   logic [2:0]  lg;
   logic        ferr;

   logic        run2, bclk2, lrclk2;
   logic [0:0]  din2;
   logic [3:0]  addr2;
   logic [15:0] wdata2;
   logic        wen2;
   logic [2:0]  lg2;
   logic        ferr2;

   i2s_multi_msb_receiver dut (
      .clk_x4_i              (clk),
      .reset_n_i             (rst_n),
      .i2s_running_i         (run),
      .i2s_bclk_i            (bclk),
      .i2s_lrclk_i           (lrclk),
      .i2s_data_i            (din),
      .ram_write_addr_o      (addr),
      .ram_write_data_o      (wdata),
      .ram_write_en_o        (wen),
      .last_good_frame_idx_o (lg),
      .frame_error_o         (ferr)
   );

   i2s_multi_msb_receiver #(
      .LINES         (1),
      .SAMPLE_BITS   (16),
      .SLOT_BITS     (17),
      .CIRC_BUF_BITS (3)
   ) dut2 (
      .clk_x4_i              (clk),
      .reset_n_i             (rst_n),
      .i2s_running_i         (run2),
      .i2s_bclk_i            (bclk2),
      .i2s_lrclk_i           (lrclk2),
      .i2s_data_i            (din2),
      .ram_write_addr_o      (addr2),
      .ram_write_data_o      (wdata2),
      .ram_write_en_o        (wen2),
      .last_good_frame_idx_o (lg2),
      .frame_error_o         (ferr2)
   );

   int checks = 0;
   int failures = 0;
   int errs = 0;
   int errs2 = 0;
   logic [5:0]  wa[$];
   logic [23:0] wd[$];
   logic [3:0]  wa2[$];
   logic [15:0] wd2[$];

   always @(negedge clk) begin
      if (wen) begin
         wa.push_back(addr);
         wd.push_back(wdata);
      end
      if (wen2) begin
         wa2.push_back(addr2);
         wd2.push_back(wdata2);
      end
      if (ferr) errs++;
      if (ferr2) errs2++;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] wv(input int f, input int l,
                                      input int ch);
      return 24'hA5A5A5 ^ 24'((f << 16) | (l << 8) | (ch << 4));
   endfunction

   task automatic edge1(input logic lr, input logic [3:0] d);
      @(negedge clk);
      bclk = 1'b0; lrclk = lr; din = d;
      @(negedge clk);
      bclk = 1'b1;
   endtask

   task automatic slot1(input logic lr, input int n, input int f);
      for (int j = 0; j < n; j++) begin
         logic [3:0]  d;
         logic [23:0] w;
         d = '0;
         if (j >= 1 && j <= 24)
            for (int l = 0; l < 4; l++) begin
               w = wv(f, l, int'(lr));
               d[l] = w[24-j];
            end
         edge1(lr, d);
      end
   endtask

   task automatic frame1(input int f, input int rlen);
      slot1(1'b0, 32, f);
      slot1(1'b1, rlen, f);
   endtask

   // Left slot writes lines 0..3 (even channels), then right (odd).
   task automatic chk_frame(input int base, input int f, input int idx);
      chk($sformatf("wcount_f%0d", f), wa.size() >= base + 8, 1);
      if (wa.size() >= base + 8)
         for (int j = 0; j < 8; j++) begin
            int l, ch;
            l = j % 4;
            ch = j / 4;
            chk($sformatf("addr[%0d]", base+j), wa[base+j],
                idx*8 + 2*l + ch);
            chk($sformatf("data[%0d]", base+j), wd[base+j],
                wv(f, l, ch));
         end
   endtask

   task automatic edge2(input logic lr, input logic d);
      @(negedge clk);
      bclk2 = 1'b0; lrclk2 = lr; din2 = d;
      @(negedge clk);
      bclk2 = 1'b1;
   endtask

   task automatic slot2(input logic lr, input int n, input logic [15:0] w);
      for (int j = 0; j < n; j++)
         edge2(lr, (j >= 1 && j <= 16) ? w[16-j] : 1'b0);
   endtask

   initial begin
      rst_n = 0; run = 0; bclk = 0; lrclk = 0; din = '0;
      run2 = 0; bclk2 = 0; lrclk2 = 0; din2 = '0;
      repeat (4) @(negedge clk);
      chk("rst_addr", addr, 0);
      chk("rst_data", wdata, 0);
      chk("rst_en", wen, 0);
      chk("rst_lg", lg, 0);
      chk("rst_ferr", ferr, 0);

      rst_n = 1; run = 1;
      slot1(1'b1, 4, 0);
      frame1(0, 32);
      chk("f0_wcount", wa.size(), 8);
      chk_frame(0, 0, 0);
      chk("f0_word0", wd[0], 24'hA5A5A5);
      chk("f0_lg", lg, 0);
      frame1(1, 32);
      chk("f1_wcount", wa.size(), 16);
      chk_frame(8, 1, 1);
      chk("f1_lg", lg, 0);
      for (int f = 2; f <= 8; f++) begin
         frame1(f, 32);
         chk($sformatf("lg_after_f%0d", f), lg, (f - 1) % 8);
      end
      chk_frame(64, 8, 0);
      frame1(9, 32);
      chk("wrap_lg", lg, 0);
      chk_frame(72, 9, 1);
      chk("no_err_yet", errs, 0);

      frame1(10, 31);
      chk("short_pre_lg", lg, 1);
      chk_frame(80, 10, 2);
      frame1(11, 32);
      chk("short_err_pulses", errs, 1);
      chk("short_lg_kept", lg, 1);
      chk_frame(88, 11, 2);

      slot1(1'b0, 20, 12);
      @(negedge clk);
      chk("pre_drop_lg", lg, 2);
      run = 0;
      slot1(1'b0, 30, 12);
      chk("drop_no_writes", wa.size(), 96);
      run = 1;
      slot1(1'b1, 4, 0);
      frame1(13, 32);
      chk("resume_wcount", wa.size(), 104);
      chk_frame(96, 13, 3);

      slot1(1'b0, 25, 14);
      @(negedge clk);
      chk("burst_en", wen, 1);
      chk("burst_addr", addr, 32);
      rst_n = 0;
      @(negedge clk);
      chk("rb_en", wen, 0);
      chk("rb_addr", addr, 0);
      chk("rb_data", wdata, 0);
      chk("rb_lg", lg, 0);
      chk("rb_ferr", ferr, 0);
      repeat (6) @(negedge clk);
      chk("rb_wcount", wa.size(), 105);
      chk("rb_word", wd[104], wv(14, 0, 0));
      rst_n = 1;
      slot1(1'b1, 4, 0);
      frame1(15, 32);
      chk("post_rst_wcount", wa.size(), 113);
      chk_frame(105, 15, 0);

      run2 = 1;
      slot2(1'b1, 4, 16'h0);
      slot2(1'b0, 17, 16'hC35A);
      slot2(1'b1, 17, 16'h1234);
      slot2(1'b0, 17, 16'h8001);
      slot2(1'b1, 17, 16'h7FFE);
      slot2(1'b0, 2, 16'h0);
      @(negedge clk);
      chk("n1_wcount", wa2.size(), 4);
      if (wa2.size() == 4) begin
         chk("n1_addr0", wa2[0], 0);
         chk("n1_addr1", wa2[1], 1);
         chk("n1_addr2", wa2[2], 2);
         chk("n1_addr3", wa2[3], 3);
         chk("n1_data0", wd2[0], 16'hC35A);
         chk("n1_data1", wd2[1], 16'h1234);
         chk("n1_data2", wd2[2], 16'h8001);
         chk("n1_data3", wd2[3], 16'h7FFE);
      end
      chk("n1_lg", lg2, 1);
      chk("n1_err", errs2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
